// File: rtl/wired_bus_pkg.sv
// Shared types and default sizing for the wired bus arbiter.
// Width helpers track the default geometry; the top re-derives them from its parameters.
package wired_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } wb_state_e;

  localparam int WB_N_REQ     = 4;
  localparam int WB_W         = 8;
  localparam int WB_BURST_MAX = 4;
  localparam int WB_OWN_W     = (WB_N_REQ > 1) ? $clog2(WB_N_REQ) : 1;
  localparam int WB_BEAT_W    = $clog2(WB_BURST_MAX) + 1;

endpackage

// File: rtl/wired_bus_arbiter_picker.sv
// Rotate-priority search: first asserted request at or above ptr, wrapping.
// Shared by the IDLE and TURN arbitration paths of the top.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner of a shared wired net with one dead cycle between owners.
// bus_out retains the last driven beat while nobody owns the net.
module wired_bus_arbiter
  import wired_bus_pkg::*;
#(
  parameter int N_REQ     = WB_N_REQ,
  parameter int W         = WB_W,
  parameter int BURST_MAX = WB_BURST_MAX
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_REQ-1:0]                          req,
  input  logic [N_REQ-1:0]                          last,
  input  logic [N_REQ*W-1:0]                        data_in,
  output logic [N_REQ-1:0]                          grant,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner,
  output logic [W-1:0]                              bus_out,
  output logic                                      bus_valid,
  output logic                                      abort
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_MAX - 1);
  localparam logic [OW-1:0] TOP_IDX   = OW'(N_REQ - 1);

  wb_state_e       r_state;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   r_owner;
  logic [BW-1:0]   r_beat;
  logic [N_REQ-1:0] r_grant;
  logic [W-1:0]    r_bus_out;
  logic            r_bus_valid;
  logic            r_abort;

  logic            w_found;
  logic [OW-1:0]   w_idx;
  logic [OW-1:0]   w_next_ptr;
  logic [W-1:0]    w_pick_data;
  logic [W-1:0]    w_own_data;
  logic            w_drop;
  logic            w_end;

  rr_picker #(
    .N  (N_REQ),
    .IW (OW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_pick_data = data_in[int'(w_idx)*W +: W];
  assign w_own_data  = data_in[int'(r_owner)*W +: W];
  assign w_next_ptr  = (r_owner == TOP_IDX) ? '0 : r_owner + 1'b1;
  // A dropped request wins over last: the burst is cut, not completed.
  assign w_drop      = !req[r_owner];
  assign w_end       = last[r_owner] || (r_beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_beat      <= '0;
      r_grant     <= '0;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      unique case (r_state)
        IDLE, TURN: begin
          if (w_found) begin
            r_state     <= OWN;
            r_owner     <= w_idx;
            r_grant     <= N_REQ'(1) << w_idx;
            r_beat      <= '0;
            r_bus_out   <= w_pick_data;
            r_bus_valid <= 1'b1;
          end else begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_bus_valid <= 1'b0;
          end
        end
        OWN: begin
          if (w_drop || w_end) begin
            r_state     <= TURN;
            r_grant     <= '0;
            r_bus_valid <= 1'b0;
            r_abort     <= w_drop;
            r_ptr       <= w_next_ptr;
          end else begin
            r_beat      <= r_beat + 1'b1;
            r_bus_out   <= w_own_data;
            r_bus_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_grant     <= '0;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign owner     = r_owner;
  assign bus_out   = r_bus_out;
  assign bus_valid = r_bus_valid;
  assign abort     = r_abort;

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Directed bench for wired_bus_arbiter: hand-derived per-cycle expectations
// queued at drive time and compared when the registered outputs appear.
module tb_wired_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  bus_out;
  logic        bus_valid;
  logic        abort;

  int n_tot;
  int n_bad;
  logic [15:0] exp_q[$];
  int seq_a[2] = '{0, 2};
  int seq_b[6] = '{3, 0, 1, 2, 3, 0};

  wired_bus_arbiter #(
    .N_REQ     (4),
    .W         (8),
    .BURST_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .grant     (grant),
    .owner     (owner),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ex(input logic [3:0] g, input int o,
                                     input logic v, input logic a,
                                     input logic [7:0] b);
    return {g, 2'(o), v, a, b};
  endfunction

  function automatic logic [7:0] dv(input int o);
    return 8'(8'h11 * (o + 1));
  endfunction

  task automatic step(input string tag, input logic rn, input logic [3:0] rq,
                      input logic [3:0] ls, input logic [15:0] e);
    logic [15:0] want;
    rst_n = rn;
    req   = rq;
    last  = ls;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    chk(tag, {16'h0, grant, owner, bus_valid, abort, bus_out}, {16'h0, want});
    chk({tag, "_1hot"}, 32'($onehot0(grant)), 32'd1);
  endtask

  initial begin
    n_tot   = 0;
    n_bad   = 0;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};

    step("rst", 1'b0, 4'b0000, 4'b0000, ex(4'b0000, 0, 0, 0, 8'h00));
    step("rst", 1'b0, 4'b0000, 4'b0000, ex(4'b0000, 0, 0, 0, 8'h00));

    for (int i = 0; i < 10; i++)
      step("idle", 1'b1, 4'b0000, 4'b0000, ex(4'b0000, 0, 0, 0, 8'h00));

    foreach (seq_a[s]) begin
      for (int b = 0; b < 4; b++)
        step("pair_beat", 1'b1, 4'b0101, 4'b0000,
             ex(4'(1 << seq_a[s]), seq_a[s], 1, 0, dv(seq_a[s])));
      step("pair_turn", 1'b1, 4'b0101, 4'b0000,
           ex(4'b0000, seq_a[s], 0, 0, dv(seq_a[s])));
    end
    step("pair_idle", 1'b1, 4'b0000, 4'b0000, ex(4'b0000, 2, 0, 0, 8'h33));

    foreach (seq_b[s]) begin
      for (int b = 0; b < 4; b++)
        step("rr_beat", 1'b1, 4'b1111, 4'b0000,
             ex(4'(1 << seq_b[s]), seq_b[s], 1, 0, dv(seq_b[s])));
      step("rr_turn", 1'b1, 4'b1111, 4'b0000,
           ex(4'b0000, seq_b[s], 0, 0, dv(seq_b[s])));
    end
    step("rr_idle", 1'b1, 4'b0000, 4'b0000, ex(4'b0000, 0, 0, 0, 8'h11));

    data_in[15:8] = 8'hA5;
    step("last_b0", 1'b1, 4'b0010, 4'b0000, ex(4'b0010, 1, 1, 0, 8'hA5));
    step("last_b1", 1'b1, 4'b0010, 4'b0000, ex(4'b0010, 1, 1, 0, 8'hA5));
    step("last_turn", 1'b1, 4'b0010, 4'b0010, ex(4'b0000, 1, 0, 0, 8'hA5));
    step("last_idle", 1'b1, 4'b0000, 4'b0000, ex(4'b0000, 1, 0, 0, 8'hA5));
    data_in[15:8] = 8'h5A;
    step("hold", 1'b1, 4'b0000, 4'b0000, ex(4'b0000, 1, 0, 0, 8'hA5));
    data_in[15:8] = 8'h22;

    step("drop_b0", 1'b1, 4'b1001, 4'b0000, ex(4'b1000, 3, 1, 0, 8'h44));
    step("drop_b1", 1'b1, 4'b1001, 4'b0000, ex(4'b1000, 3, 1, 0, 8'h44));
    step("drop_abort", 1'b1, 4'b0001, 4'b1000, ex(4'b0000, 3, 0, 1, 8'h44));
    for (int b = 0; b < 4; b++)
      step("drop_next", 1'b1, 4'b0001, 4'b0000, ex(4'b0001, 0, 1, 0, 8'h11));
    step("lone_turn", 1'b1, 4'b0001, 4'b0000, ex(4'b0000, 0, 0, 0, 8'h11));
    step("lone_again", 1'b1, 4'b0001, 4'b0000, ex(4'b0001, 0, 1, 0, 8'h11));
    step("lone_b1", 1'b1, 4'b0011, 4'b0000, ex(4'b0001, 0, 1, 0, 8'h11));

    step("mid_rst", 1'b0, 4'b0011, 4'b0000, ex(4'b0000, 0, 0, 0, 8'h00));
    step("post_rst", 1'b1, 4'b0011, 4'b0000, ex(4'b0001, 0, 1, 0, 8'h11));
    step("end_abort", 1'b1, 4'b0000, 4'b0000, ex(4'b0000, 0, 0, 1, 8'h11));
    step("end_idle", 1'b1, 4'b0000, 4'b0000, ex(4'b0000, 0, 0, 0, 8'h11));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
